dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port 8-bit data memory between the CPU datapath (port 0) and a second bus master (port 1), such as a program/data loader or debug/DMA engine. It sits between both masters and the data memory's address/write-data/write-enable inputs. Arbitration is round-robin with a bounded burst length, so a continuously requesting master cannot starve the other. It also drives a stall signal that the CPU uses to hold the program counter while port 0 is waiting.

## Interface
- `ADDR_W`, default 8: address width of both ports and of the memory.
- `DATA_W`, default 8: data width of both ports and of the memory.
- `BURST_MAX`, default 4: maximum consecutive grant cycles to one port while the other port is requesting; legal values ≥ 1.

One clock; reset is synchronous and active-high.

- `CLK`  in  1  rising-edge clock.
- `RESET`  in  1  synchronous, active-high reset.
- `REQ0`, `REQ1`  in  1  access request from port 0 / port 1, level-held until granted.
- `WE0`, `WE1`  in  1  1 = write, 0 = read.
- `ADDR0`, `ADDR1`  in  ADDR_W  access address.
- `WDATA0`, `WDATA1`  in  DATA_W  write data.
- `GNT0`, `GNT1`  out  1  access performed this cycle.
- `RDATA0`, `RDATA1`  out  DATA_W  read data, valid when the matching GNT is high and WE is 0.
- `STALL0`  out  1  REQ0 & ~GNT0; feeds the CPU program-counter hold.
- `MEM_ADDR`  out  ADDR_W  address to data memory.
- `MEM_WDATA`  out  DATA_W  write data to data memory.
- `MEM_WE`  out  1  write enable to data memory.
- `MEM_RDATA`  in  DATA_W  combinational read data from data memory.
- `LOCK1`  in  1  present only with `DMEM_ARB_LOCK_EN`.

## Operation
**State registers**
- `owner_q`: one of OWN_NONE, OWN_P0, OWN_P1; records who held the previous cycle.
- `cnt_q`: consecutive grant count, width $clog2(BURST_MAX+1).
- `last_q`: last served port.

**Grant decision** (combinational, from the state registers and the current REQs)
- No request: no grant.
- Only one REQ high: grant that port, regardless of `cnt_q`.
- Both REQs high, `owner_q` = Pi and `cnt_q` < BURST_MAX: grant Pi.
- Both REQs high, `owner_q` = Pi and `cnt_q` = BURST_MAX: grant the other port.
- Both REQs high, `owner_q` = OWN_NONE: grant the port ≠ `last_q`.

**State update at each clock edge**
- Grant to Pi: `owner_q` ← Pi; `last_q` ← Pi.
- `cnt_q` ← `cnt_q`+1, saturating at BURST_MAX, if `owner_q` was already Pi; otherwise `cnt_q` ← 1.
- No grant: `owner_q` ← OWN_NONE; `cnt_q` ← 0; `last_q` unchanged.

**Memory mux**
- `MEM_ADDR`, `MEM_WDATA` and `MEM_WE` (= WEi) follow the granted port.
- With no grant: `MEM_WE` = 0, and `MEM_ADDR` and `MEM_WDATA` = 0.
- `RDATA0` and `RDATA1` both equal `MEM_RDATA` gated to 0 when their port is not granted.

## Timing
- Grant and access take zero latency: a request presented in cycle N is serviced in cycle N if granted. A write commits at the rising edge ending cycle N; read data is valid within cycle N.
- A requester keeps REQ, WE, ADDR and WDATA stable until it sees GNT. It may drop REQ in the cycle after GNT or hold it for back-to-back accesses.
- **Reset**
  - While `RESET` = 1, all outputs are forced to 0: GNT0, GNT1, STALL0, MEM_* and RDATA*.
  - At the edge: `owner_q` = OWN_NONE, `cnt_q` = 0, `last_q` = P1, so P0 wins the first tie.
  - Reset mid-burst discards the burst count.
- **Priority handover:** when the owner drops REQ while the other port is requesting, the other port is granted that same cycle with no idle cycle inserted.
- **Saturation:** with only one requester, `cnt_q` saturates at BURST_MAX. If the other port then requests, it wins in the very next cycle.

## Configuration
- `DMEM_ARB_LOCK_EN` defined:
  - Adds the `LOCK1` input.
  - While `owner_q` = OWN_P1 and `LOCK1` = 1, the burst limit is ignored for P1, so P1 keeps the grant while REQ1 is held (atomic loader sequences).
  - `LOCK1` has no effect unless P1 already owns the port.
- Not defined: the `LOCK1` port is absent and the burst limit always applies.

## Structure
- Shared package `dmem_arb_pkg`:
  - `owner_t` enum: OWN_NONE, OWN_P0, OWN_P1.
  - Default width constants `DMEM_ADDR_W` = 8 and `DMEM_DATA_W` = 8.
- One sub-module, `dmem_arb_pick`: the combinational grant decision, with inputs REQ0, REQ1, `owner_q`, `cnt_q`, `last_q` and lock, and outputs GNT0 and GNT1. It is instantiated once.
- The state registers and the memory mux live in `dmem_arbiter`.

## Test plan
All scenarios use BURST_MAX = 4 unless stated otherwise.
1. **Reset:** RESET=1 for 2 cycles with REQ0=REQ1=1 → GNT0=GNT1=0 and MEM_WE=0 throughout. In the first cycle after release, GNT0=1 and STALL0=0.
2. **Write then read back:** REQ1=1, WE1=1, ADDR1=8'h10, WDATA1=8'hA5 for 1 cycle → GNT1=1, MEM_WE=1, MEM_ADDR=8'h10. Next cycle, P0 reads 8'h10 → GNT0=1, RDATA0=8'hA5, RDATA1=0.
3. **Fairness:** both REQs held for 16 cycles from idle → grants P0×4, P1×4, P0×4, P1×4. STALL0=1 exactly during the P1 cycles.
4. **Late joiner:** P0 alone for 3 cycles, then REQ1 rises while P0 continues → P0 is granted 1 more cycle (count reaches 4), then P1 is granted.
5. **Tie after idle and handover:**
   - P0 served, one idle cycle, then both request → P1 wins.
   - P1 drops REQ after 2 cycles → P0 is granted in the next cycle with no gap.
6. **Lock (DMEM_ARB_LOCK_EN):** P1 owns the port, LOCK1=1, both REQs held for 10 cycles → GNT1=1 for all 10 cycles. Deassert LOCK1 → P0 is granted on the next cycle.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and default widths for the data-memory arbiter
package dmem_arb_pkg;
    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester ports and memory-side bus of the data-memory arbiter
// Optional LOCK1 signal present only when DMEM_ARB_LOCK_EN is defined.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) ();
    logic              REQ0;
    logic              REQ1;
    logic              WE0;
    logic              WE1;
    logic [ADDR_W-1:0] ADDR0;
    logic [ADDR_W-1:0] ADDR1;
    logic [DATA_W-1:0] WDATA0;
    logic [DATA_W-1:0] WDATA1;
    logic              GNT0;
    logic              GNT1;
    logic [DATA_W-1:0] RDATA0;
    logic [DATA_W-1:0] RDATA1;
    logic              STALL0;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic              MEM_WE;
    logic [DATA_W-1:0] MEM_RDATA;
`ifdef DMEM_ARB_LOCK_EN
    logic              LOCK1;
`endif

    modport slave (
        input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, MEM_RDATA,
`ifdef DMEM_ARB_LOCK_EN
        input  LOCK1,
`endif
        output GNT0, GNT1, RDATA0, RDATA1, STALL0, MEM_ADDR, MEM_WDATA, MEM_WE
    );

    modport master (
        output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, MEM_RDATA,
`ifdef DMEM_ARB_LOCK_EN
        output LOCK1,
`endif
        input  GNT0, GNT1, RDATA0, RDATA1, STALL0, MEM_ADDR, MEM_WDATA, MEM_WE
    );
endinterface

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - combinational round-robin grant decision with burst limit and P1 lock
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int CNT_W     = 3,
    parameter int BURST_MAX = 4
) (
    input  logic             req0,
    input  logic             req1,
    input  owner_t           owner_q,
    input  logic [CNT_W-1:0] cnt_q,
    input  owner_t           last_q,
    input  logic             lock,
    output logic             gnt0,
    output logic             gnt1
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && !req1) begin
            gnt0 = 1'b1;
        end else if (req1 && !req0) begin
            gnt1 = 1'b1;
        end else if (req0 && req1) begin
            // Contention: the current owner keeps the memory until its burst is spent.
            case (owner_q)
                OWN_P0: begin
                    if (cnt_q < CNT_MAX) gnt0 = 1'b1;
                    else                 gnt1 = 1'b1;
                end
                OWN_P1: begin
                    if (lock || cnt_q < CNT_MAX) gnt1 = 1'b1;
                    else                         gnt0 = 1'b1;
                end
                default: begin
                    if (last_q == OWN_P1) gnt0 = 1'b1;
                    else                  gnt1 = 1'b1;
                end
            endcase
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin, burst-bounded arbiter sharing one data memory between two masters
// Optional feature: DMEM_ARB_LOCK_EN adds LOCK1 so an owning P1 ignores the burst limit.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = DMEM_ADDR_W,
    parameter int DATA_W    = DMEM_DATA_W,
    parameter int BURST_MAX = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    dmem_arbiter_if.slave bus
);
    localparam int               CNT_W   = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

    owner_t            owner_q, owner_d;
    owner_t            last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pick0, pick1;
    logic              gnt0, gnt1;
    logic              lock;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;

`ifdef DMEM_ARB_LOCK_EN
    assign lock = bus.LOCK1;
`else
    assign lock = 1'b0;
`endif

    dmem_arb_pick #(
        .CNT_W     (CNT_W),
        .BURST_MAX (BURST_MAX)
    ) u_pick (
        .req0    (bus.REQ0),
        .req1    (bus.REQ1),
        .owner_q (owner_q),
        .cnt_q   (cnt_q),
        .last_q  (last_q),
        .lock    (lock),
        .gnt0    (pick0),
        .gnt1    (pick1)
    );

    // Reset silences every grant, so the memory sees no access while RESET is high.
    assign gnt0 = pick0 & ~RESET;
    assign gnt1 = pick1 & ~RESET;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            owner_q <= OWN_NONE;
            cnt_q   <= '0;
            last_q  <= OWN_P1;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        cnt_d   = '0;
        last_d  = last_q;
        if (gnt0 || gnt1) begin
            owner_d = gnt0 ? OWN_P0 : OWN_P1;
            last_d  = owner_d;
            if (owner_q == owner_d) cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
            else                    cnt_d = CNT_W'(1);
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (gnt0) begin
            mem_addr  = bus.ADDR0;
            mem_wdata = bus.WDATA0;
            mem_we    = bus.WE0;
        end else if (gnt1) begin
            mem_addr  = bus.ADDR1;
            mem_wdata = bus.WDATA1;
            mem_we    = bus.WE1;
        end
    end

    assign bus.MEM_ADDR  = mem_addr;
    assign bus.MEM_WDATA = mem_wdata;
    assign bus.MEM_WE    = mem_we;
    assign bus.GNT0      = gnt0;
    assign bus.GNT1      = gnt1;
    assign bus.STALL0    = bus.REQ0 & ~gnt0 & ~RESET;
    assign bus.RDATA0    = gnt0 ? bus.MEM_RDATA : '0;
    assign bus.RDATA1    = gnt1 ? bus.MEM_RDATA : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter (LOCK1 scenario with DMEM_ARB_LOCK_EN)
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int BM = 4;

    logic CLK = 1'b0;
    logic RESET;
    int   tests = 0;
    int   fails = 0;

    always #5 CLK = ~CLK;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    logic [DW-1:0] mem [256];
    assign bus.MEM_RDATA = mem[bus.MEM_ADDR];

    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 256; i++) mem[i] <= DW'(i ^ 'h5A);
        end else if (bus.MEM_WE) begin
            mem[bus.MEM_ADDR] <= bus.MEM_WDATA;
        end
    end

    // Reference model: grant history since reset plus a shadow copy of memory.
    int            hist[$];
    int            last_srv;
    logic [DW-1:0] ref_mem [256];

    function automatic void model_reset();
        hist.delete();
        last_srv = 1;
        for (int i = 0; i < 256; i++) ref_mem[i] = DW'(i ^ 'h5A);
    endfunction

    function automatic int model_pick(bit r0, bit r1, bit lk);
        int prev;
        int run;
        if (!r0 && !r1) return -1;
        if (r0 != r1) return r0 ? 0 : 1;
        if (hist.size() == 0 || hist[$] < 0) return 1 - last_srv;
        prev = hist[$];
        run  = 0;
        for (int i = hist.size() - 1; i >= 0 && hist[i] == prev; i--) run++;
        if (prev == 1 && lk) return 1;
        return (run >= BM) ? 1 - prev : prev;
    endfunction

    function automatic bit cur_lock();
`ifdef DMEM_ARB_LOCK_EN
        return bus.LOCK1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int dut_grant();
        if (bus.GNT0 && bus.GNT1) return 2;
        if (bus.GNT0) return 0;
        if (bus.GNT1) return 1;
        return -1;
    endfunction

    task automatic drive(input int p, input bit req, input bit we, input int addr, input int wd);
        if (p == 0) begin
            bus.REQ0 = req; bus.WE0 = we; bus.ADDR0 = AW'(addr); bus.WDATA0 = DW'(wd);
        end else begin
            bus.REQ1 = req; bus.WE1 = we; bus.ADDR1 = AW'(addr); bus.WDATA1 = DW'(wd);
        end
    endtask

    task automatic sample(output int gm, output int gd);
        @(negedge CLK);
        gm = model_pick(bus.REQ0, bus.REQ1, cur_lock());
        gd = dut_grant();
    endtask

    task automatic advance(input int g);
        hist.push_back(g);
        if (g == 0) begin
            last_srv = 0;
            if (bus.WE0) ref_mem[bus.ADDR0] = bus.WDATA0;
        end else if (g == 1) begin
            last_srv = 1;
            if (bus.WE1) ref_mem[bus.ADDR1] = bus.WDATA1;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        int gm, gd;
        RESET = 1'b1;
        drive(0, 1, 0, 3, 0);
        drive(1, 1, 0, 4, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            tests++;
            if ({bus.GNT0, bus.GNT1, bus.MEM_WE, bus.STALL0} !== 4'b0000) begin
                fails++;
                $display("FAIL reset_ctrl: got gnt0/gnt1/we/stall=%b expected 0000",
                         {bus.GNT0, bus.GNT1, bus.MEM_WE, bus.STALL0});
            end
            tests++;
            if (bus.MEM_ADDR !== '0 || bus.MEM_WDATA !== '0 || bus.RDATA0 !== '0 || bus.RDATA1 !== '0) begin
                fails++;
                $display("FAIL reset_data: got addr=%h wdata=%h rd0=%h rd1=%h expected all 0",
                         bus.MEM_ADDR, bus.MEM_WDATA, bus.RDATA0, bus.RDATA1);
            end
            @(posedge CLK);
            #1;
        end
        RESET = 1'b0;
        model_reset();
        sample(gm, gd);
        tests++;
        if (gd !== 0) begin fails++; $display("FAIL reset_first_grant: got %0d expected 0", gd); end
        tests++;
        if (bus.STALL0 !== 1'b0) begin fails++; $display("FAIL reset_first_stall: got %b expected 0", bus.STALL0); end
        advance(gm);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
    endtask

    task automatic test_write_read();
        int gm, gd;
        drive(1, 1, 1, 'h10, 'hA5);
        sample(gm, gd);
        tests++;
        if (gd !== 1 || bus.MEM_WE !== 1'b1 || bus.MEM_ADDR !== 8'h10 || bus.MEM_WDATA !== 8'hA5) begin
            fails++;
            $display("FAIL write_p1: got gnt=%0d we=%b addr=%h wdata=%h expected 1 1 10 a5",
                     gd, bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WDATA);
        end
        advance(gm);
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 'h10, 0);
        sample(gm, gd);
        tests++;
        if (gd !== 0 || bus.RDATA0 !== 8'hA5 || bus.RDATA1 !== 8'h00 || bus.MEM_WE !== 1'b0) begin
            fails++;
            $display("FAIL read_p0: got gnt=%0d rd0=%h rd1=%h we=%b expected 0 a5 00 0",
                     gd, bus.RDATA0, bus.RDATA1, bus.MEM_WE);
        end
        advance(gm);
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_fairness();
        int gm, gd, exp_g;
        do_reset();
        drive(0, 1, 0, 'h21, 0);
        drive(1, 1, 0, 'h42, 0);
        for (int i = 0; i < 16; i++) begin
            sample(gm, gd);
            exp_g = (i / BM) % 2;
            tests++;
            if (gd !== exp_g) begin fails++; $display("FAIL fairness_grant[%0d]: got %0d expected %0d", i, gd, exp_g); end
            tests++;
            if (bus.STALL0 !== (exp_g == 1)) begin
                fails++;
                $display("FAIL fairness_stall[%0d]: got %b expected %b", i, bus.STALL0, exp_g == 1);
            end
            advance(gm);
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
    endtask

    task automatic test_late_joiner();
        int gm, gd, exp_g;
        do_reset();
        drive(0, 1, 1, 'h30, 'h11);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) drive(1, 1, 0, 'h31, 0);
            sample(gm, gd);
            exp_g = (i < BM) ? 0 : 1;
            tests++;
            if (gd !== exp_g) begin fails++; $display("FAIL late_joiner[%0d]: got %0d expected %0d", i, gd, exp_g); end
            advance(gm);
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
    endtask

    task automatic test_tie_handover();
        int gm, gd;
        bit r0v[5] = '{1, 0, 1, 1, 1};
        bit r1v[5] = '{0, 0, 1, 1, 0};
        int ev[5]  = '{0, -1, 1, 1, 0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, r0v[i], 0, 'h50, 0);
            drive(1, r1v[i], 0, 'h51, 0);
            sample(gm, gd);
            tests++;
            if (gd !== ev[i]) begin fails++; $display("FAIL tie_handover[%0d]: got %0d expected %0d", i, gd, ev[i]); end
            advance(gm);
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
    endtask

`ifdef DMEM_ARB_LOCK_EN
    task automatic test_lock();
        int gm, gd;
        do_reset();
        bus.LOCK1 = 1'b1;
        drive(1, 1, 0, 'h60, 0);
        sample(gm, gd);
        tests++;
        if (gd !== 1) begin fails++; $display("FAIL lock_own: got %0d expected 1", gd); end
        advance(gm);
        drive(0, 1, 0, 'h61, 0);
        for (int i = 0; i < 10; i++) begin
            sample(gm, gd);
            tests++;
            if (gd !== 1) begin fails++; $display("FAIL lock_hold[%0d]: got %0d expected 1", i, gd); end
            advance(gm);
        end
        bus.LOCK1 = 1'b0;
        sample(gm, gd);
        tests++;
        if (gd !== 0) begin fails++; $display("FAIL lock_release: got %0d expected 0", gd); end
        advance(gm);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
    endtask
`endif

    task automatic test_random();
        bit rq[2];
        bit we[2];
        int ad[2];
        int wd[2];
        int gm, gd;
        bit rst_now;
        bit exp_we;
        int exp_addr, exp_wd;
        logic [DW-1:0] exp_rd0, exp_rd1;
        for (int p = 0; p < 2; p++) begin rq[p] = 0; we[p] = 0; ad[p] = 0; wd[p] = 0; end
        for (int c = 0; c < 800; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rq[p] && $urandom_range(0, 2) != 0) begin
                    rq[p] = 1;
                    we[p] = 1'($urandom_range(0, 1));
                    ad[p] = $urandom_range(0, 15);
                    wd[p] = $urandom_range(0, 255);
                end
                drive(p, rq[p], we[p], ad[p], wd[p]);
            end
`ifdef DMEM_ARB_LOCK_EN
            bus.LOCK1 = ($urandom_range(0, 3) != 0);
`endif
            rst_now = ($urandom_range(0, 60) == 0);
            RESET = rst_now;
            @(negedge CLK);
            if (rst_now) begin
                tests++;
                if ({bus.GNT0, bus.GNT1, bus.MEM_WE, bus.STALL0} !== 4'b0000) begin
                    fails++;
                    $display("FAIL rand_reset[%0d]: got gnt0/gnt1/we/stall=%b expected 0000",
                             c, {bus.GNT0, bus.GNT1, bus.MEM_WE, bus.STALL0});
                end
                @(posedge CLK);
                #1;
                RESET = 1'b0;
                model_reset();
                continue;
            end
            gm = model_pick(rq[0], rq[1], cur_lock());
            gd = dut_grant();
            exp_we   = (gm >= 0) ? we[gm] : 1'b0;
            exp_addr = (gm >= 0) ? ad[gm] : 0;
            exp_wd   = (gm >= 0) ? wd[gm] : 0;
            exp_rd0  = (gm == 0) ? ref_mem[ad[0]] : '0;
            exp_rd1  = (gm == 1) ? ref_mem[ad[1]] : '0;
            tests++;
            if (gd !== gm) begin fails++; $display("FAIL rand_grant[%0d]: got %0d expected %0d", c, gd, gm); end
            tests++;
            if (bus.STALL0 !== (rq[0] && gm != 0)) begin
                fails++;
                $display("FAIL rand_stall[%0d]: got %b expected %b", c, bus.STALL0, rq[0] && gm != 0);
            end
            tests++;
            if (bus.MEM_WE !== exp_we || bus.MEM_ADDR !== AW'(exp_addr) || bus.MEM_WDATA !== DW'(exp_wd)) begin
                fails++;
                $display("FAIL rand_mem[%0d]: got we=%b addr=%h wdata=%h expected %b %h %h",
                         c, bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WDATA, exp_we, AW'(exp_addr), DW'(exp_wd));
            end
            tests++;
            if (bus.RDATA0 !== exp_rd0 || bus.RDATA1 !== exp_rd1) begin
                fails++;
                $display("FAIL rand_rdata[%0d]: got rd0=%h rd1=%h expected %h %h",
                         c, bus.RDATA0, bus.RDATA1, exp_rd0, exp_rd1);
            end
            advance(gm);
            if (gm >= 0) rq[gm] = 0;
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
`ifdef DMEM_ARB_LOCK_EN
        bus.LOCK1 = 1'b0;
`endif
        model_reset();
        test_reset();
        test_write_read();
        test_fairness();
        test_late_joiner();
        test_tie_handover();
`ifdef DMEM_ARB_LOCK_EN
        test_lock();
        bus.LOCK1 = 1'b0;
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
